// File: rtl/calc_op_sequencer_pkg.sv
// calc_pkg: shared constants, FSM/op enums and helpers for the calculator sequencer.
// Optional divide path is selected by the CALC_DIV_EN macro (see calc_op_sequencer).
package calc_pkg;

  // op_req bit indices
  localparam int unsigned OP_ADD  = 0;
  localparam int unsigned OP_SUB  = 1;
  localparam int unsigned OP_MUL  = 2;
  localparam int unsigned OP_DIV  = 3;
  localparam int unsigned OP_SHOW = 4;

  // Result width feeding the double-dabble converter (max 99*99 = 9801).
  localparam int unsigned RES_W = 14;

  // Upper bound on divide iterations; quotient never exceeds DIV_MAX_ITER - 1.
  localparam int unsigned DIV_MAX_ITER = 100;

  localparam logic [3:0] DIGIT_MINUS = 4'd10;
  localparam logic [3:0] DIGIT_ERR   = 4'd11;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StConv,
    StWrite
  } state_e;

  typedef enum logic [1:0] {
    OpAdd,
    OpSub,
    OpMul,
    OpDiv
  } op_e;

  // Decimal digit increment with 9 -> 0 wrap.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/calc_op_sequencer_if.sv
// calc_op_sequencer_if: button requests in, status and display digits out.
//   inc_req[3:0]  increment pulses for operand digits 1..4
//   op_req[4:0]   {show, div, mul, sub, add} request pulses
//   busy/done/err status, digit1..digit4 display codes (10 = minus, 11 = error)
// master = request source (buttons / bench), slave = sequencer.
interface calc_op_sequencer_if;
  logic [3:0] inc_req;
  logic [4:0] op_req;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;

  modport master (
    output inc_req, op_req,
    input  busy, done, err, digit1, digit2, digit3, digit4
  );

  modport slave (
    input  inc_req, op_req,
    output busy, done, err, digit1, digit2, digit3, digit4
  );
endinterface

// File: rtl/calc_op_sequencer_bin2bcd.sv
// bin2bcd_seq: sequential 14-bit binary to 4-digit BCD converter (double-dabble).
//   clk_in, reset  clock and synchronous active-low reset
//   start          load bin and begin a conversion (one RES_W-step pass)
//   bin            binary value, sampled when start is high
//   done           high during the cycle in which the final step is applied
//   bcd[15:0]      result digits, most significant nibble first; valid after done
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic             done,
  output logic [15:0]      bcd
);
  logic [RES_W-1:0] sh_q;
  logic [15:0]      bcd_q;
  logic [3:0]       cnt_q;
  logic [15:0]      adj;

  // Add-3 correction on every nibble that would overflow past 9 when doubled.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sh_q  <= bin;
      bcd_q <= '0;
      cnt_q <= 4'(RES_W);
    end else if (cnt_q != 4'd0) begin
      bcd_q <= {adj[14:0], sh_q[RES_W-1]};
      sh_q  <= {sh_q[RES_W-2:0], 1'b0};
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done = (cnt_q == 4'd1);
  assign bcd  = bcd_q;
endmodule

// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer: four-digit calculator sequencer. Holds the two 2-digit BCD operands,
// accepts increment/op pulses in idle, runs add/sub/mul/div through a shared execute stage
// and the bin2bcd_seq converter, and registers the four display digits.
//   clk_in  system clock
//   reset   synchronous active-low reset
//   bus     calc_op_sequencer_if.slave (requests in, busy/done/err/digits out)
// Build option: CALC_DIV_EN compiles in the divide path and err; otherwise op_req[3] is
// ignored and err is tied low.
module calc_op_sequencer
  import calc_pkg::*;
(
  input logic                clk_in,
  input logic                reset,
  calc_op_sequencer_if.slave bus
);
  state_e           state_q;
  op_e              op_q;
  op_e              req_op;
  logic             req_valid, req_show;
  logic [3:0]       opd_q   [4];
  logic [3:0]       opd_inc [4];
  logic [3:0]       dig_q   [4];
  logic [6:0]       a_q, b_q, opnd_a, opnd_b;
  logic             busy_q, done_q;
  logic [RES_W-1:0] exec_res;
  logic             exec_ready, div_zero, a_lt_b;
  logic             bcd_start, bcd_done;
  logic [15:0]      bcd;
`ifdef CALC_DIV_EN
  logic [6:0]       rem_q, quo_q;
  logic             err_q;
`else
  logic             unused_div_req;
  assign unused_div_req = bus.op_req[OP_DIV];
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) opd_inc[i] = bus.inc_req[i] ? bcd_inc(opd_q[i]) : opd_q[i];
  end

  assign opnd_a = 7'(opd_q[0]) * 7'd10 + 7'(opd_q[1]);
  assign opnd_b = 7'(opd_q[2]) * 7'd10 + 7'(opd_q[3]);

  // Priority: show > div > mul > sub > add.
  always_comb begin
    req_valid = 1'b1;
    req_show  = 1'b0;
    req_op    = OpAdd;
    if (bus.op_req[OP_SHOW]) req_show = 1'b1;
`ifdef CALC_DIV_EN
    else if (bus.op_req[OP_DIV]) req_op = OpDiv;
`endif
    else if (bus.op_req[OP_MUL]) req_op = OpMul;
    else if (bus.op_req[OP_SUB]) req_op = OpSub;
    else if (!bus.op_req[OP_ADD]) req_valid = 1'b0;
  end

  always_comb begin
    a_lt_b     = (a_q < b_q);
    exec_ready = 1'b1;
    div_zero   = 1'b0;
    unique case (op_q)
      OpAdd:   exec_res = RES_W'(a_q) + RES_W'(b_q);
      OpSub:   exec_res = a_lt_b ? RES_W'(b_q - a_q) : RES_W'(a_q - b_q);
      OpMul:   exec_res = RES_W'(a_q) * RES_W'(b_q);
      default: exec_res = '0;
    endcase
`ifdef CALC_DIV_EN
    if (op_q == OpDiv) begin
      exec_res   = RES_W'(quo_q);
      div_zero   = (b_q == 7'd0);
      exec_ready = div_zero || (rem_q < b_q) || (32'(quo_q) >= DIV_MAX_ITER - 1);
    end
`endif
  end

  assign bcd_start = (state_q == StExec) && exec_ready && !div_zero;

  bin2bcd_seq u_bin2bcd (
    .clk_in (clk_in),
    .reset  (reset),
    .start  (bcd_start),
    .bin    (exec_res),
    .done   (bcd_done),
    .bcd    (bcd)
  );

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        opd_q[i] <= '0;
        dig_q[i] <= '0;
      end
`ifdef CALC_DIV_EN
      rem_q <= '0;
      quo_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_show) begin
            for (int i = 0; i < 4; i++) dig_q[i] <= opd_q[i];
            done_q <= 1'b1;
`ifdef CALC_DIV_EN
            err_q <= 1'b0;
`endif
          end else if (req_valid) begin
            // Working copies isolate the operation from later operand edits.
            op_q    <= req_op;
            a_q     <= opnd_a;
            b_q     <= opnd_b;
            busy_q  <= 1'b1;
            state_q <= StExec;
`ifdef CALC_DIV_EN
            rem_q <= opnd_a;
            quo_q <= '0;
            err_q <= 1'b0;
`endif
          end else if (|bus.inc_req) begin
            for (int i = 0; i < 4; i++) begin
              opd_q[i] <= opd_inc[i];
              dig_q[i] <= opd_inc[i];
            end
            done_q <= 1'b1;
          end
        end
        StExec: begin
`ifdef CALC_DIV_EN
          if (!exec_ready) begin
            rem_q <= rem_q - b_q;
            quo_q <= quo_q + 7'd1;
          end else
`endif
          if (div_zero) state_q <= StWrite;
          else          state_q <= StConv;
        end
        StConv: begin
          if (bcd_done) state_q <= StWrite;
        end
        StWrite: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          unique case (op_q)
            OpAdd, OpSub: begin
              dig_q[0] <= (op_q == OpSub && a_lt_b) ? DIGIT_MINUS : 4'd0;
              dig_q[1] <= bcd[11:8];
              dig_q[2] <= bcd[7:4];
              dig_q[3] <= bcd[3:0];
            end
            OpMul: begin
              dig_q[0] <= bcd[15:12];
              dig_q[1] <= bcd[11:8];
              dig_q[2] <= bcd[7:4];
              dig_q[3] <= bcd[3:0];
            end
            default: begin
`ifdef CALC_DIV_EN
              if (b_q == 7'd0) begin
                for (int i = 0; i < 4; i++) dig_q[i] <= DIGIT_ERR;
                err_q <= 1'b1;
              end else begin
                dig_q[0] <= 4'd0;
                dig_q[1] <= 4'd0;
                dig_q[2] <= bcd[7:4];
                dig_q[3] <= bcd[3:0];
              end
`endif
            end
          endcase
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.digit1 = dig_q[0];
  assign bus.digit2 = dig_q[1];
  assign bus.digit3 = dig_q[2];
  assign bus.digit4 = dig_q[3];
`ifdef CALC_DIV_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif
endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Sequencing controller for the four-digit calculator datapath. Owns the two 2-digit BCD operands, accepts one-cycle increment and operation request pulses from the debounced push-buttons, and runs each operation through a shared multi-cycle execute/convert path. Drives the four display digits consumed by the seven-segment scan/decoder stage. Replaces the per-button edge-triggered logic with a single-clock FSM.

## Interface
- DIV_MAX_ITER, 100: upper bound on divide iterations; the quotient is at most 99.
- clk_in  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- inc_req  input  4  one-cycle pulses; bit i increments operand digit i+1 (digit1..digit4).
- op_req  input  5  one-cycle pulses, bits {show, div, mul, sub, add} = [4:0].
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when the display digits update.
- err  output  1  high after divide-by-zero; cleared on the next accepted op_req.
- digit1, digit2, digit3, digit4  output  4 each  display codes: 0–9, 10 = minus, 11 = error glyph.

## Operation
- Operands: A = d1·10 + d2 and B = d3·10 + d4, each in the range 0..99. Operand digits wrap 9→0 on increment.
- Increment in IDLE:
  - All set inc_req bits apply in the same cycle.
  - The display digits then show d1..d4.
- FSM states: IDLE, EXEC, CONV, WRITE.
  - IDLE→EXEC on an accepted add/sub/mul/div request.
  - EXEC→CONV when the result is ready.
  - CONV→WRITE when bin2bcd_seq signals done.
  - WRITE→IDLE unconditionally.
- show: handled entirely in IDLE. Display = d1..d4 on the next edge, done pulses, no busy.
- add: R = A + B (0..198). digit1 = 0; digit2..digit4 = BCD(R).
- sub: if A ≥ B, digit1 = 0; otherwise digit1 = 10. digit2..digit4 = BCD(|A − B|).
- mul: R = A·B (0..9801, 14 bits). digit1..digit4 = BCD(R).
- div: repeated subtraction. Each EXEC cycle subtracts B from the remainder while remainder ≥ B.
  - Quotient Q = ⌊A/B⌋.
  - digit1 = digit2 = 0; digit3, digit4 = BCD(Q).
- div with B = 0:
  - EXEC lasts 1 cycle and the CONV state is skipped.
  - All four digits = 11, err = 1.
- Simultaneous requests: priority is show > div > mul > sub > add.
  - An op_req in the same cycle as inc_req wins; the inc_req is dropped.
- Any inc_req or op_req while busy is dropped silently. There is no queue.
- Operands are captured into working registers when a request is accepted, so later operand edits cannot corrupt the operation in flight.

## Timing
- Reset values:
  - All digits = 0 and all operand digits = 0.
  - busy = 0, done = 0, err = 0.
  - State = IDLE.
- Reset mid-operation aborts immediately. No done pulse is produced.
- A request is accepted at edge n. busy = (state ≠ IDLE) and rises after edge n.
- EXEC length: add/sub/mul take 1 cycle; div takes Q + 1 cycles.
- CONV: fixed 14 cycles (14-bit double-dabble).
- WRITE: digits update at the WRITE edge, and done is high for the following cycle, coincident with busy falling.
- Total latency, request edge to digit update:
  - add/sub/mul: 16 cycles.
  - div: 16 + Q cycles.
  - div by zero: 2 cycles.
  - show/inc: 1 cycle.
- Digits hold their value between updates.

## Configuration
- CALC_DIV_EN defined: divide path, DIV_MAX_ITER guard and err logic are compiled in.
- CALC_DIV_EN undefined:
  - op_req[3] is ignored and does not take part in priority.
  - err is tied to 0.
  - The divide remainder/quotient registers are absent.

## Structure
- Package calc_pkg holds:
  - the op_req bit-index constants;
  - the FSM state enum;
  - DIGIT_MINUS = 4'd10 and DIGIT_ERR = 4'd11;
  - RES_W = 14.
- Sub-module bin2bcd_seq:
  - 14-bit to 4-digit sequential double-dabble.
  - Ports: start, bin, done, bcd[15:0].
  - Instantiated once and shared by add/sub/mul/div.

## Test plan
- Reset, then 3×inc_req[0], 5×inc_req[3] → display 3,0,0,5; A = 30, B = 5.
- A = 45, B = 67, add → done at +16 cycles; digits 0,1,1,2.
- A = 12, B = 47, sub → digits 10,0,3,5; later A = 47, B = 47, sub → 0,0,0,0.
- A = 99, B = 99, mul → digits 9,8,0,1; an add pulse mid-operation is dropped with no extra done.
- A = 99, B = 1, div → done at +115 cycles, digits 0,0,9,9. B = 0, div → 11,11,11,11 with err = 1; the next add clears err.
- Reset asserted mid-div → all outputs 0 on the next edge, no done. Simultaneous add + mul in IDLE → mul result.
